// File: rtl/pixel_fifo_split.sv
// Pixel FIFO between a frame reader and VGA timing, with SOF tag, level flags and sticky errors.
// Latency: a write is readable from the next edge; an accepted read shows on pix_out one edge later.
// Backpressure: full/almost_full throttle the source; writes while full (no read) are dropped and flagged.
module pixel_fifo_split #(
  parameter int CH_W           = 8,
  parameter int NCH            = 3,
  parameter int DEPTH          = 16,
  parameter int AF_LVL         = DEPTH - 4,
  parameter int AE_LVL         = 4,
  parameter int UNDERRUN_BLACK = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [NCH*CH_W-1:0]     din,
  input  logic                    din_sof,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [NCH*CH_W-1:0]     pix_out,
  output logic                    pix_sof,
  output logic                    pix_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    underrun
);

  localparam int PW = NCH * CH_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LVL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LVL);

  // Each entry carries the SOF tag in its top bit.
  logic [PW:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wp;
  logic [AW-1:0]  r_rp;
  logic [LW-1:0]  r_level;
  logic [PW-1:0]  r_pix;
  logic           r_sof;
  logic           r_vld;
  logic           r_ovf;
  logic           r_unr;

  logic           w_full;
  logic           w_empty;
  logic           w_wr_acc;
  logic           w_rd_acc;

  // Flags decode from the registered level only.
  assign w_full   = (r_level == DEPTH_L);
  assign w_empty  = (r_level == '0);
  // A read in the same cycle frees a slot, so a write at full still goes in.
  assign w_wr_acc = wr_en && (!w_full || rd_en);
  // No fall-through: a read on an empty FIFO is always an underrun.
  assign w_rd_acc = rd_en && !w_empty;

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp] <= {din_sof, din};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_acc) r_wp <= r_wp + 1'b1;
      if (w_rd_acc) r_rp <= r_rp + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_level <= r_level + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_level <= r_level - 1'b1;
    end
  end

  // Registered output pixel; valid pulses once per accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix <= '0;
      r_sof <= 1'b0;
      r_vld <= 1'b0;
    end else if (w_rd_acc) begin
      r_pix <= r_mem[r_rp][PW-1:0];
      r_sof <= r_mem[r_rp][PW];
      r_vld <= 1'b1;
    end else begin
      r_sof <= 1'b0;
      r_vld <= 1'b0;
      if (rd_en && (UNDERRUN_BLACK != 0)) r_pix <= '0;
    end
  end

  // Sticky errors; a fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unr <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !clr_err) || (wr_en && w_full && !rd_en);
      r_unr <= (r_unr && !clr_err) || (rd_en && w_empty);
    end
  end

  assign pix_out      = r_pix;
  assign pix_sof      = r_sof;
  assign pix_valid    = r_vld;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_level >= AF_L);
  assign almost_empty = (r_level <= AE_L);
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underrun     = r_unr;

endmodule

// File: tb/tb_pixel_fifo_split.sv
module tb_pixel_fifo_split;

  localparam int PW    = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [PW-1:0] din = '0;
  logic          din_sof = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;

  logic [PW-1:0] pix_b, pix_h;
  logic          sof_b, sof_h, vld_b, vld_h;
  logic          full_b, full_h, empty_b, empty_h, af_b, af_h, ae_b, ae_h;
  logic [4:0]    lvl_b, lvl_h;
  logic          ovf_b, ovf_h, unr_b, unr_h;

  // Blanking variant
  pixel_fifo_split #(.CH_W(8), .NCH(3), .DEPTH(DEPTH), .UNDERRUN_BLACK(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .din_sof(din_sof),
    .rd_en(rd_en), .clr_err(clr_err), .pix_out(pix_b), .pix_sof(sof_b),
    .pix_valid(vld_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .level(lvl_b), .overflow(ovf_b), .underrun(unr_b));

  // Hold-last variant, same stimulus
  pixel_fifo_split #(.CH_W(8), .NCH(3), .DEPTH(DEPTH), .UNDERRUN_BLACK(0)) dut_h (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .din_sof(din_sof),
    .rd_en(rd_en), .clr_err(clr_err), .pix_out(pix_h), .pix_sof(sof_h),
    .pix_valid(vld_h), .full(full_h), .empty(empty_h), .almost_full(af_h),
    .almost_empty(ae_h), .level(lvl_h), .overflow(ovf_h), .underrun(unr_h));

  always #5 clk = ~clk;

  // Reference model: a queue of {sof, pixel} plus expected output state.
  logic [PW:0]   q[$];
  logic [PW-1:0] m_pix_b, m_pix_h;
  logic          m_sof, m_vld, m_ovf, m_unr;
  int            n_assert = 0;
  int            n_fail   = 0;
  int            n_wr_acc = 0;
  int            max_lvl  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pix_b = '0; m_pix_h = '0;
    m_sof = 1'b0; m_vld = 1'b0; m_ovf = 1'b0; m_unr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ":level"}, 32'(lvl_b), 32'(sz));
    chk({tag, ":level_h"}, 32'(lvl_h), 32'(sz));
    chk({tag, ":full"}, 32'(full_b), 32'(sz == DEPTH));
    chk({tag, ":empty"}, 32'(empty_b), 32'(sz == 0));
    chk({tag, ":afull"}, 32'(af_b), 32'(sz >= DEPTH - 4));
    chk({tag, ":aempty"}, 32'(ae_b), 32'(sz <= 4));
    chk({tag, ":valid"}, 32'(vld_b), 32'(m_vld));
    chk({tag, ":valid_h"}, 32'(vld_h), 32'(m_vld));
    chk({tag, ":sof"}, 32'(sof_b), 32'(m_sof));
    chk({tag, ":pix_blank"}, 32'(pix_b), 32'(m_pix_b));
    chk({tag, ":pix_hold"}, 32'(pix_h), 32'(m_pix_h));
    chk({tag, ":overflow"}, 32'(ovf_b), 32'(m_ovf));
    chk({tag, ":underrun"}, 32'(unr_b), 32'(m_unr));
  endtask

  // One clock cycle of stimulus, model update, and full check.
  task automatic step(input string tag, input logic wr, input logic [PW-1:0] d,
                      input logic s, input logic rd, input logic clr);
    int sz;
    logic [PW:0] e;
    @(negedge clk);
    wr_en = wr; din = d; din_sof = s; rd_en = rd; clr_err = clr;
    @(posedge clk);
    sz = q.size();
    m_ovf = (m_ovf && !clr) || (wr && sz == DEPTH && !rd);
    m_unr = (m_unr && !clr) || (rd && sz == 0);
    if (rd && sz > 0) begin
      e = q.pop_front();
      m_pix_b = e[PW-1:0]; m_pix_h = e[PW-1:0]; m_sof = e[PW]; m_vld = 1'b1;
    end else begin
      m_vld = 1'b0; m_sof = 1'b0;
      if (rd) m_pix_b = '0;
    end
    if (wr && (sz < DEPTH || rd)) begin
      q.push_back({s, d});
      n_wr_acc++;
    end
    if (q.size() > max_lvl) max_lvl = q.size();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill with ramp, then read back in order
    for (int i = 0; i < 16; i++) step("fill", 1'b1, PW'(i), i == 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("idle_after_drain", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Overflow: dropped write, then clear, then write+read at full
    for (int i = 0; i < 16; i++) step("fill2", 1'b1, PW'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    step("ovf_write", 1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
    step("ovf_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("ovf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("wr_rd_full", 1'b1, 24'h000055, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("drain2", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Underrun blank vs hold
    step("unr_empty", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("unr_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("wr_123456", 1'b1, 24'h123456, 1'b0, 1'b0, 1'b0);
    step("rd_123456", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("unr_hold", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("unr_clr_vs_new", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    step("unr_clr2", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("wr_rd_empty", 1'b1, 24'h0A0B0C, 1'b0, 1'b1, 1'b0);
    step("rd_last", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("clr_all", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Random interleaved stream; wraps pointers at least twice
    n_wr_acc = 0;
    max_lvl = 0;
    for (int c = 0; c < 400 && n_wr_acc < 48; c++) begin
      step("rand", 1'($urandom_range(0, 99) < 60), PW'($urandom),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 9) == 0));
    end
    chk("rand_writes", 32'(n_wr_acc >= 40), 32'd1);
    chk("rand_max_level", 32'(max_lvl <= DEPTH), 32'd1);
    while (q.size() > 0) step("rand_drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Mid-stream asynchronous reset at level 7, during a read
    for (int i = 0; i < 8; i++) step("pre_rst", 1'b1, PW'(32'h700 + i), i == 0, 1'b0, 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1'b0;
    step("post_rst_rd", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fifo_split.md
# pixel_fifo_split

Parametrised single-clock pixel buffer that sits between a pixel source (ROM/frame reader) and the VGA timing logic. It stores NCH-channel pixels with a start-of-frame tag, provides level and threshold flags for source throttling, and presents each read pixel as a registered, channel-packed bus. Overflow and underrun are detected and held as sticky error flags. Underrun output is configurable as blanked or held.

## Interface
- CH_W, 8, bits per colour channel
- NCH, 3, channels per pixel; channel k occupies bits [k*CH_W +: CH_W], channel 0 = red
- DEPTH, 16, entries; power of two, ≥4
- AF_LVL, DEPTH-4, almost_full asserted when level ≥ AF_LVL
- AE_LVL, 4, almost_empty asserted when level ≤ AE_LVL
- UNDERRUN_BLACK, 1, 1 = drive zero pixel on underrun; 0 = hold last pixel

- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- din  in  NCH*CH_W  pixel to write
- din_sof  in  1  start-of-frame tag stored with din
- rd_en  in  1  read request (from VGA logic)
- clr_err  in  1  synchronous clear of sticky errors
- pix_out  out  NCH*CH_W  registered pixel
- pix_sof  out  1  registered SOF tag of pix_out
- pix_valid  out  1  pix_out holds a real FIFO entry this cycle
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AF_LVL
- almost_empty  out  1  level ≤ AE_LVL
- level  out  log2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: write attempted while full
- underrun  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×(NCH*CH_W+1) register array, write pointer wp and read pointer rp, each log2(DEPTH) bits, wrap modulo DEPTH; separate occupancy counter level.
- Write accepted iff wr_en && !full, or wr_en && full && rd_en (simultaneous read frees a slot). Accepted write stores {din_sof, din} at wp; wp increments.
- Read accepted iff rd_en && !empty. Accepted read loads entry at rp into pix_out/pix_sof, sets pix_valid=1, increments rp.
- rd_en && empty: no pointer change; pix_valid=0; pix_sof=0; pix_out=0 if UNDERRUN_BLACK else unchanged; underrun set.
- rd_en low: pix_valid=0, pix_sof=0, pix_out holds.
- wr_en && full && !rd_en: write dropped, array/wp unchanged, overflow set.
- Write and read both attempted while empty: the write is accepted; the read is an underrun (no fall-through).
- level: +1 on accepted write only, −1 on accepted read only, unchanged when both or neither are accepted.
- Flags full/empty/almost_full/almost_empty are decoded combinationally from the registered level.
- clr_err clears overflow and underrun. If a new error occurs in the same cycle, the error wins and the flag stays 1.

## Timing
- Reset (rst=0, async): wp=rp=0, level=0, pix_out=0, pix_sof=0, pix_valid=0, overflow=0, underrun=0. Flags at reset: empty=1, almost_empty=1, full=0, almost_full=0. Array contents are don't-care.
- Reset release is synchronous to clk: the first edge with rst=1 may accept a write.
- Read latency: an entry accepted on edge N appears on pix_out with pix_valid=1 after edge N; pix_valid stays high for exactly one cycle per accepted read.
- A write on edge N is readable from edge N+1; empty deasserts after edge N.
- Back-to-back rd_en every cycle with level ≥ 1 yields one pixel per cycle.
- Reset asserted mid-stream discards all entries and errors immediately; no partial pixel is emitted.

## Test plan
- Reset, then write 16 pixels with din = 0x000000+i and din_sof=1 on i=0 -> full=1, level=16, almost_full=1 from level 12; reads return 0x000000..0x00000F in order, pix_sof=1 only on the first, pix_valid high one cycle after each rd_en.
- Fill to 16, write 0xABCDEF -> overflow=1, level stays 16, and that pixel never appears; clr_err -> overflow=0.
- Empty FIFO, rd_en pulse with UNDERRUN_BLACK=1 -> pix_out=0, pix_valid=0, underrun=1; repeat with UNDERRUN_BLACK=0 after a read of 0x123456 -> pix_out stays 0x123456.
- Simultaneous wr_en/rd_en at level=16 -> write accepted, no overflow, level=16; at level=0 -> write accepted, underrun=1, level=1.
- Stream of 40 writes interleaved with reads so the pointers wrap twice -> output order is intact and level never exceeds 16.
- Assert rst at level=7 mid-read -> all outputs return to reset values asynchronously; after release, the first read underruns.
